// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd - iterative double-dabble binary to 3-digit BCD converter.
//
// Converts an N_BITS binary operand (4..9 bits, max 511) into hundreds,
// tens and units BCD digits using one ADD cycle and one SHIFT cycle per
// operand bit. A single-cycle in_INIT pulse in IDLE starts a conversion;
// out_DONE pulses for one cycle when the new digits are on the outputs.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   in_BIN   - binary operand, sampled on the accept edge only
//   in_INIT  - start request, honoured only in IDLE
//   out_CEN  - hundreds digit (registered)
//   out_DEC  - tens digit (registered)
//   out_UND  - units digit (registered)
//   out_BUSY - high from the accept edge until DONE is left
//   out_DONE - one-cycle completion pulse
//
// Optional feature macro: BIN2BCD_ZERO_BLANK_EN
//   When defined, leading zeros are blanked (shown as 4'hF) at the output
//   register load; the units digit is never blanked.

module bin2bcd_dd #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] in_BIN,
  input  logic              in_INIT,
  output logic [3:0]        out_CEN,
  output logic [3:0]        out_DEC,
  output logic [3:0]        out_UND,
  output logic              out_BUSY,
  output logic              out_DONE
);

  localparam int W = 12 + N_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] K_INIT = 4'(N_BITS);

  // Working register layout: {C[3:0], D[3:0], U[3:0], B[N_BITS-1:0]}
  logic [1:0]   r_state;
  logic [W-1:0] r_work;
  logic [3:0]   r_k;
  logic [3:0]   r_cen;
  logic [3:0]   r_dec;
  logic [3:0]   r_und;

  logic [W-1:0] w_add;
  logic [W-1:0] w_shift;
  logic [3:0]   w_k_dec;
  logic [3:0]   w_c;
  logic [3:0]   w_d;
  logic [3:0]   w_u;
  logic [3:0]   w_cen_out;
  logic [3:0]   w_dec_out;
  logic [3:0]   w_und_out;

  // Double-dabble correction: a digit >= 5 would become >= 10 after the
  // shift, so pre-add 3 to make the shift carry into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  assign w_add = {add3(r_work[W-1 -: 4]),
                  add3(r_work[W-5 -: 4]),
                  add3(r_work[W-9 -: 4]),
                  r_work[N_BITS-1:0]};

  assign w_shift = {r_work[W-2:0], 1'b0};
  assign w_k_dec = r_k - 4'd1;

  // Digits as they stand after the final shift, loaded on the same edge
  assign w_c = w_shift[W-1 -: 4];
  assign w_d = w_shift[W-5 -: 4];
  assign w_u = w_shift[W-9 -: 4];

`ifdef BIN2BCD_ZERO_BLANK_EN
  assign w_cen_out = (w_c == 4'd0) ? 4'hF : w_c;
  assign w_dec_out = ((w_c == 4'd0) && (w_d == 4'd0)) ? 4'hF : w_d;
`else
  assign w_cen_out = w_c;
  assign w_dec_out = w_d;
`endif
  assign w_und_out = w_u;

  // Conversion FSM, working register, iteration counter and result digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_k     <= 4'd0;
      r_cen   <= 4'd0;
      r_dec   <= 4'd0;
      r_und   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_INIT) begin
            r_work  <= {12'd0, in_BIN};
            r_k     <= K_INIT;
            r_state <= S_ADD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          r_work  <= w_add;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_work <= w_shift;
          r_k    <= w_k_dec;
          if (w_k_dec == 4'd0) begin
            r_cen   <= w_cen_out;
            r_dec   <= w_dec_out;
            r_und   <= w_und_out;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          // Always pass through IDLE so the issue interval is 2*N_BITS+2
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_CEN  = r_cen;
  assign out_DEC  = r_dec;
  assign out_UND  = r_und;
  assign out_BUSY = (r_state != S_IDLE);
  assign out_DONE = (r_state == S_DONE);

endmodule

// File: tb/tb_bin2bcd_dd.sv
// tb_bin2bcd_dd - self-checking bench for bin2bcd_dd (N_BITS = 8).
// A behavioural model tracks the accept/complete timing and computes the
// expected digits with decimal arithmetic; a negedge process compares all
// outputs every cycle. Directed runs pin the model with literal results.

module tb_bin2bcd_dd;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_BIN;
  logic       in_INIT;
  logic [3:0] out_CEN;
  logic [3:0] out_DEC;
  logic [3:0] out_UND;
  logic       out_BUSY;
  logic       out_DONE;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bin2bcd_dd #(.N_BITS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_BIN   (in_BIN),
    .in_INIT  (in_INIT),
    .out_CEN  (out_CEN),
    .out_DEC  (out_DEC),
    .out_UND  (out_UND),
    .out_BUSY (out_BUSY),
    .out_DONE (out_DONE)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for interval measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected displayed digits {C,D,U} for a value, from decimal arithmetic
  function automatic logic [11:0] dec3(input int v);
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    c = 4'(v / 100);
    d = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef BIN2BCD_ZERO_BLANK_EN
    if (v < 100) c = 4'hF;
    if (v < 10)  d = 4'hF;
`endif
    return {c, d, u};
  endfunction

  // Behavioural model: m_t = cycles since accept, -1 when idle
  int         m_t;
  int         m_val;
  logic [3:0] m_cen;
  logic [3:0] m_dec;
  logic [3:0] m_und;
  logic       m_done;

  // Model update on each clock edge / reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    <= -1;
      m_val  <= 0;
      m_cen  <= 4'd0;
      m_dec  <= 4'd0;
      m_und  <= 4'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_t < 0) begin
        if (in_INIT) begin
          m_t   <= 0;
          m_val <= int'(in_BIN);
        end
      end else if (m_t == 2*N - 1) begin
        m_t    <= m_t + 1;
        {m_cen, m_dec, m_und} <= dec3(m_val);
        m_done <= 1'b1;
      end else if (m_t == 2*N) begin
        m_t <= -1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("busy", int'(out_BUSY), int'(m_t >= 0));
    chk("done", int'(out_DONE), int'(m_done));
    chk("cen",  int'(out_CEN),  int'(m_cen));
    chk("dec",  int'(out_DEC),  int'(m_dec));
    chk("und",  int'(out_UND),  int'(m_und));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single conversion with literal expectations and latency check
  task automatic run_one(input logic [7:0] v, input logic [3:0] ec,
                         input logic [3:0] ed, input logic [3:0] eu);
    int n;
    n = 0;
    in_BIN  = v;
    in_INIT = 1'b1;
    tick();
    in_INIT = 1'b0;
    chk("busy_after_accept", int'(out_BUSY), 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_DONE) begin
        n = i;
        break;
      end
    end
    chk("done_latency", n, 2*N);
    chk("lit_cen", int'(out_CEN), int'(ec));
    chk("lit_dec", int'(out_DEC), int'(ed));
    chk("lit_und", int'(out_UND), int'(eu));
    chk("busy_at_done", int'(out_BUSY), 1);
    tick();
    chk("busy_after_done", int'(out_BUSY), 0);
    chk("done_one_cycle", int'(out_DONE), 0);
  endtask

  initial begin
    int dones;
    int last_done;
    int n;
    logic [11:0] e;

    rst     = 1'b1;
    in_INIT = 1'b0;
    in_BIN  = 8'd0;
    repeat (3) tick();
    chk("rst_busy", int'(out_BUSY), 0);
    chk("rst_done", int'(out_DONE), 0);
    chk("rst_digits", int'({out_CEN, out_DEC, out_UND}), 0);
    rst = 1'b0;
    tick();

    // Directed values with hand-computed results
`ifdef BIN2BCD_ZERO_BLANK_EN
    run_one(8'd0,   4'hF, 4'hF, 4'd0);
    run_one(8'd255, 4'd2, 4'd5, 4'd5);
    run_one(8'd99,  4'hF, 4'd9, 4'd9);
    run_one(8'd100, 4'd1, 4'd0, 4'd0);
    run_one(8'd47,  4'hF, 4'd4, 4'd7);
    run_one(8'd7,   4'hF, 4'hF, 4'd7);
    run_one(8'd42,  4'hF, 4'd4, 4'd2);
    run_one(8'd105, 4'd1, 4'd0, 4'd5);
`else
    run_one(8'd0,   4'd0, 4'd0, 4'd0);
    run_one(8'd255, 4'd2, 4'd5, 4'd5);
    run_one(8'd99,  4'd0, 4'd9, 4'd9);
    run_one(8'd100, 4'd1, 4'd0, 4'd0);
    run_one(8'd47,  4'd0, 4'd4, 4'd7);
    run_one(8'd7,   4'd0, 4'd0, 4'd7);
    run_one(8'd105, 4'd1, 4'd0, 4'd5);
`endif

    // Exhaustive back-to-back sweep with in_INIT held high
    last_done = 0;
    in_BIN  = 8'd0;
    in_INIT = 1'b1;
    for (int v = 0; v < 256; v++) begin
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (out_DONE) begin
          n = i;
          break;
        end
      end
      chk("sweep_done_seen", int'(n != 0), 1);
      if (v > 0) chk("sweep_interval", cyc - last_done, 2*N + 2);
      last_done = cyc;
      e = dec3(v);
      chk("sweep_digits", int'({out_CEN, out_DEC, out_UND}), int'(e));
      in_BIN = 8'(v + 1);
    end
    in_INIT = 1'b0;
    repeat (20) tick();

    // in_INIT during a conversion is ignored
    in_BIN  = 8'd200;
    in_INIT = 1'b1;
    tick();
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3 || i == 10) begin
        in_INIT = 1'b1;
        in_BIN  = 8'd13;
      end else begin
        in_INIT = 1'b0;
      end
      tick();
      if (out_DONE) dones++;
    end
    chk("ignore_done_count", dones, 1);
    chk("ignore_digits", int'({out_CEN, out_DEC, out_UND}), int'(dec3(200)));

    // Reset mid-conversion aborts without a done pulse
    in_BIN  = 8'd123;
    in_INIT = 1'b1;
    tick();
    in_INIT = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(out_BUSY), 0);
    chk("abort_done", int'(out_DONE), 0);
    chk("abort_digits", int'({out_CEN, out_DEC, out_UND}), 0);
    tick();
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_DONE) dones++;
    end
    chk("abort_no_done", dones, 0);
`ifdef BIN2BCD_ZERO_BLANK_EN
    run_one(8'd45, 4'hF, 4'd4, 4'd5);
`else
    run_one(8'd45, 4'd0, 4'd4, 4'd5);
`endif

    // Randomized start requests and operands, checked by the model
    for (int i = 0; i < 600; i++) begin
      in_INIT = ($urandom_range(0, 3) == 0);
      in_BIN  = 8'($urandom);
      tick();
    end
    in_INIT = 1'b0;
    repeat (25) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
